// File: rtl/ins_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
package ins_fetch_pkg;

    // Width of one instruction word.
    localparam int INS_W = 32;

    // Fetch address used after reset.
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // Queue entries and maximum number of in-flight fetches.
    localparam int FETCH_DEPTH = 4;

    // Clear the byte-offset bits so the address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched instructions. Entries are allocated at tail when a
// request is accepted, filled in order at fill when the response returns, and
// retired from head when decode consumes them. Flush empties everything.
module fetch_queue
    import ins_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alloc_i,
    input  logic [31:0]            pc_in_i,
    input  logic                   fill_i,
    input  logic [INS_W-1:0]       data_in_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic [$clog2(DEPTH):0] pending_o,
    output logic                   head_filled_o,
    output logic [31:0]            head_pc_o,
    output logic [INS_W-1:0]       head_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    fill_q, fill_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [INS_W-1:0] data_mem_q [DEPTH];

    // Next-state pointer arithmetic; a flush overrides every other event.
    always_comb begin
        head_d = head_q;
        fill_d = fill_q;
        tail_d = tail_q;
        if (flush_i) begin
            head_d = {PW{1'b0}};
            fill_d = {PW{1'b0}};
            tail_d = {PW{1'b0}};
        end else begin
            if (alloc_i) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (fill_i) begin
                fill_d = fill_q + PTR_ONE;
            end else begin
                fill_d = fill_q;
            end
            if (pop_i) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= {PW{1'b0}};
            fill_q <= {PW{1'b0}};
            tail_q <= {PW{1'b0}};
        end else begin
            head_q <= head_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage: PC written on allocation, data written on fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= 32'h0000_0000;
                data_mem_q[i] <= {INS_W{1'b0}};
            end
        end else if (!flush_i) begin
            if (alloc_i) begin
                pc_mem_q[tail_q[AW-1:0]] <= pc_in_i;
            end
            if (fill_i) begin
                data_mem_q[fill_q[AW-1:0]] <= data_in_i;
            end
        end
    end

    assign occupancy_o   = tail_q - head_q;
    assign pending_o     = tail_q - fill_q;
    assign head_filled_o = (head_q != fill_q);
    assign head_pc_o     = pc_mem_q[head_q[AW-1:0]];
    assign head_data_o   = data_mem_q[head_q[AW-1:0]];

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: issues sequential word fetches under a credit limit,
// queues in-order responses and hands them to decode over valid/ready. A
// redirect flushes the queue and arranges for stale responses to be dropped.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int          DEPTH    = FETCH_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             IMEM_REQ,
    output logic [31:0]      IMEM_ADDR,
    input  logic             IMEM_RDY,
    input  logic             IMEM_RVALID,
    input  logic [INS_W-1:0] IMEM_RDATA,
    output logic [INS_W-1:0] INS,
    output logic [31:0]      INS_PC,
    output logic             INS_VALID,
    input  logic             INS_READY,
    input  logic             REDIRECT,
    input  logic [31:0]      REDIRECT_PC
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] CNT_ONE = PW'(1);
    localparam logic [PW:0]   DEPTH_W = DEPTH[PW:0];

    logic [31:0]      pc_q, pc_d;
    logic [PW-1:0]    drop_q, drop_d;

    logic [PW-1:0]    occ_s;
    logic [PW-1:0]    pend_s;
    logic             head_filled_s;
    logic [31:0]      head_pc_s;
    logic [INS_W-1:0] head_data_s;
    logic [PW:0]      credit_used_s;
    logic             req_s;
    logic             xfer_s;
    logic             outstanding_s;
    logic             drop_rsp_s;
    logic             fill_s;
    logic             valid_s;
    logic             pop_s;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i         (CLK),
        .rst_i         (RST),
        .alloc_i       (xfer_s),
        .pc_in_i       (pc_q),
        .fill_i        (fill_s),
        .data_in_i     (IMEM_RDATA),
        .pop_i         (pop_s),
        .flush_i       (REDIRECT),
        .occupancy_o   (occ_s),
        .pending_o     (pend_s),
        .head_filled_o (head_filled_s),
        .head_pc_o     (head_pc_s),
        .head_data_o   (head_data_s)
    );

    // Issue credit, response steering and decode handshake. Queued entries plus
    // responses still to be discarded may never exceed the queue depth, which
    // also bounds the number of requests outstanding at the memory.
    always_comb begin
        credit_used_s = {1'b0, occ_s} + {1'b0, drop_q};
        req_s         = !RST && !REDIRECT && (credit_used_s < DEPTH_W);
        xfer_s        = req_s && IMEM_RDY;
        outstanding_s = (drop_q != {PW{1'b0}}) || (pend_s != {PW{1'b0}});
        drop_rsp_s    = IMEM_RVALID && (drop_q != {PW{1'b0}});
        fill_s        = IMEM_RVALID && !REDIRECT && (drop_q == {PW{1'b0}})
                        && (pend_s != {PW{1'b0}});
        valid_s       = head_filled_s && !REDIRECT;
        pop_s         = valid_s && INS_READY;
    end

    // Next PC and drop count. On a redirect every request not yet answered
    // becomes stale, less the one whose response lands in this same cycle.
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (REDIRECT) begin
            pc_d = word_align(REDIRECT_PC);
            if (IMEM_RVALID && outstanding_s) begin
                drop_d = drop_q + pend_s - CNT_ONE;
            end else begin
                drop_d = drop_q + pend_s;
            end
        end else begin
            if (xfer_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            if (drop_rsp_s) begin
                drop_d = drop_q - CNT_ONE;
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // PC and drop-counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q   <= RESET_PC;
            drop_q <= {PW{1'b0}};
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    assign IMEM_REQ  = req_s;
    assign IMEM_ADDR = pc_q;
    assign INS_VALID = valid_s;
    assign INS       = valid_s ? head_data_s : {INS_W{1'b0}};
    assign INS_PC    = valid_s ? head_pc_s : 32'h0000_0000;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with an in-order, fixed-latency memory model
// that answers each address A with the word A + 0x13.
module tb_ins_fetch;

    localparam int DEPTH_TB = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RDY = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic [31:0] INS;
    logic [31:0] INS_PC;
    logic        INS_VALID;
    logic        INS_READY = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;

    int checks = 0;
    int errors = 0;
    int mem_k = 1;
    int cyc = 0;
    int xfer_cnt = 0;
    logic [31:0] addr_q[$];
    int          t_q[$];

    ins_fetch dut (
        .CLK         (CLK),
        .RST         (RST),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RDY    (IMEM_RDY),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .INS         (INS),
        .INS_PC      (INS_PC),
        .INS_VALID   (INS_VALID),
        .INS_READY   (INS_READY),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC)
    );

    always #5 CLK = ~CLK;

    // Memory model: record accepted requests, retire presented responses.
    always @(posedge CLK) begin
        if (RST) begin
            addr_q.delete();
            t_q.delete();
        end else begin
            if (IMEM_RVALID) begin
                void'(addr_q.pop_front());
                void'(t_q.pop_front());
            end
            if (IMEM_REQ && IMEM_RDY) begin
                addr_q.push_back(IMEM_ADDR);
                t_q.push_back(cyc);
                xfer_cnt++;
            end
        end
        cyc++;
    end

    // Memory model: present the oldest response once its latency has elapsed.
    always @(negedge CLK) begin
        if (addr_q.size() > 0 && cyc >= t_q[0] + mem_k) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = addr_q[0] + 32'h13;
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = 32'h0;
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Hold reset two cycles, then release; caller continues in the first
    // cycle after reset.
    task automatic do_reset();
        RST = 1'b1;
        REDIRECT = 1'b0;
        IMEM_RDY = 1'b0;
        INS_READY = 1'b0;
        tick();
        tick();
        xfer_cnt = 0;
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        IMEM_RDY = 1'b1;
        tick();
        tick();
        checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", IMEM_REQ); end
        checks++; if (INS_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", INS_VALID); end
        checks++; if (INS !== 32'h0) begin errors++; $display("FAIL reset_ins got %h want 0", INS); end
        checks++; if (INS_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", INS_PC); end
        checks++; if (IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", IMEM_ADDR); end
    endtask

    task automatic test_stream();
        mem_k = 1;
        do_reset();
        IMEM_RDY = 1'b1;
        INS_READY = 1'b1;
        #1;
        checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL stream_first_req got %b/%h want 1/0", IMEM_REQ, IMEM_ADDR); end
        tick();
        checks++; if (INS_VALID !== 1'b0) begin errors++; $display("FAIL stream_no_bypass got %b want 0", INS_VALID); end
        tick();
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (INS_VALID !== 1'b1 || INS_PC !== 32'(4 * n) || INS !== 32'(4 * n + 32'h13)) begin
                errors++;
                $display("FAIL stream_n%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         n, INS_VALID, INS_PC, INS, 32'(4 * n), 32'(4 * n + 32'h13));
            end
            tick();
        end
    endtask

    task automatic test_full();
        mem_k = 1;
        do_reset();
        IMEM_RDY = 1'b1;
        INS_READY = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (xfer_cnt !== 4) begin errors++; $display("FAIL full_xfers got %0d want 4", xfer_cnt); end
        checks++; if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h10) begin errors++; $display("FAIL full_req got %b/%h want 0/10", IMEM_REQ, IMEM_ADDR); end
        INS_READY = 1'b1;
        #1;
        checks++; if (IMEM_REQ !== 1'b0 || INS_PC !== 32'h0) begin errors++; $display("FAIL full_pop_cycle got req=%b pc=%h want 0/0", IMEM_REQ, INS_PC); end
        tick();
        INS_READY = 1'b0;
        #1;
        checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h10) begin errors++; $display("FAIL full_reissue got %b/%h want 1/10", IMEM_REQ, IMEM_ADDR); end
        checks++; if (INS_PC !== 32'h4) begin errors++; $display("FAIL full_next_head got %h want 4", INS_PC); end
    endtask

    task automatic test_redirect();
        int waited;
        mem_k = 4;
        do_reset();
        IMEM_RDY = 1'b1;
        INS_READY = 1'b1;
        tick();
        tick();
        tick();
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0103;
        #1;
        checks++; if (IMEM_REQ !== 1'b0 || addr_q.size() !== 3) begin errors++; $display("FAIL redir_req got req=%b inflight=%0d want 0/3", IMEM_REQ, addr_q.size()); end
        tick();
        REDIRECT = 1'b0;
        #1;
        checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin errors++; $display("FAIL redir_new_addr got %b/%h want 1/100", IMEM_REQ, IMEM_ADDR); end
        waited = 0;
        while (INS_VALID !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++; if (waited !== 5) begin errors++; $display("FAIL redir_latency got %0d want 5", waited); end
        checks++; if (INS_PC !== 32'h100 || INS !== 32'h113) begin errors++; $display("FAIL redir_first got pc=%h ins=%h want 100/113", INS_PC, INS); end
        tick();
        checks++; if (INS_VALID !== 1'b1 || INS_PC !== 32'h104) begin errors++; $display("FAIL redir_second got v=%b pc=%h want 1/104", INS_VALID, INS_PC); end
        mem_k = 1;
    endtask

    task automatic test_redirect_rvalid_pop();
        mem_k = 1;
        do_reset();
        IMEM_RDY = 1'b1;
        INS_READY = 1'b1;
        tick();
        tick();
        tick();
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0202;
        #1;
        checks++; if (IMEM_RVALID !== 1'b1 || INS_VALID !== 1'b0 || INS !== 32'h0) begin errors++; $display("FAIL rdp_cycle got rv=%b v=%b ins=%h want 1/0/0", IMEM_RVALID, INS_VALID, INS); end
        tick();
        REDIRECT = 1'b0;
        #1;
        checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h200 || INS_VALID !== 1'b0) begin errors++; $display("FAIL rdp_req got %b/%h v=%b want 1/200/0", IMEM_REQ, IMEM_ADDR, INS_VALID); end
        tick();
        checks++; if (INS_VALID !== 1'b0) begin errors++; $display("FAIL rdp_stale got v=%b pc=%h want 0", INS_VALID, INS_PC); end
        tick();
        checks++; if (INS_VALID !== 1'b1 || INS_PC !== 32'h200 || INS !== 32'h213) begin errors++; $display("FAIL rdp_first got v=%b pc=%h ins=%h want 1/200/213", INS_VALID, INS_PC, INS); end
        tick();
        checks++; if (INS_VALID !== 1'b1 || INS_PC !== 32'h204) begin errors++; $display("FAIL rdp_second got v=%b pc=%h want 1/204", INS_VALID, INS_PC); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int popped;
        int n;
        mem_k = 2;
        do_reset();
        exp_pc = 32'h0;
        popped = 0;
        n = 0;
        while (popped < 1000 && n < 20000) begin
            IMEM_RDY = ($urandom_range(0, 3) != 0);
            INS_READY = ($urandom_range(0, 2) != 0);
            REDIRECT = ($urandom_range(0, 49) == 0);
            REDIRECT_PC = $urandom;
            #1;
            checks++;
            if (REDIRECT) begin
                if (INS_VALID !== 1'b0) begin errors++; $display("FAIL rand_redir_valid got %b want 0", INS_VALID); end
                exp_pc = REDIRECT_PC & 32'hFFFF_FFFC;
            end else if (INS_VALID === 1'b1) begin
                if (INS_PC !== exp_pc || INS !== exp_pc + 32'h13) begin
                    errors++;
                    $display("FAIL rand_seq got pc=%h ins=%h want pc=%h ins=%h", INS_PC, INS, exp_pc, exp_pc + 32'h13);
                end
                if (INS_READY) begin
                    exp_pc = exp_pc + 32'd4;
                    popped++;
                end
            end else begin
                if (INS !== 32'h0 || INS_PC !== 32'h0) begin errors++; $display("FAIL rand_idle got pc=%h ins=%h want 0/0", INS_PC, INS); end
            end
            checks++;
            if (addr_q.size() > DEPTH_TB) begin errors++; $display("FAIL rand_inflight got %0d want <=%0d", addr_q.size(), DEPTH_TB); end
            tick();
            n++;
        end
        REDIRECT = 1'b0;
        checks++;
        if (popped < 1000) begin errors++; $display("FAIL rand_timeout got %0d pops want 1000", popped); end
    endtask

    task automatic test_reset_mid();
        mem_k = 1;
        do_reset();
        IMEM_RDY = 1'b1;
        INS_READY = 1'b0;
        tick();
        tick();
        IMEM_RDY = 1'b0;
        tick();
        checks++; if (INS_VALID !== 1'b1 || INS_PC !== 32'h0) begin errors++; $display("FAIL mid_queued got v=%b pc=%h want 1/0", INS_VALID, INS_PC); end
        RST = 1'b1;
        tick();
        checks++; if (INS_VALID !== 1'b0 || IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL mid_reset got v=%b req=%b addr=%h want 0/0/0", INS_VALID, IMEM_REQ, IMEM_ADDR); end
        RST = 1'b0;
        IMEM_RDY = 1'b1;
        #1;
        checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0 || INS_VALID !== 1'b0) begin errors++; $display("FAIL mid_restart got req=%b addr=%h v=%b want 1/0/0", IMEM_REQ, IMEM_ADDR, INS_VALID); end
        tick();
        tick();
        checks++; if (INS_VALID !== 1'b1 || INS_PC !== 32'h0 || INS !== 32'h13) begin errors++; $display("FAIL mid_first got v=%b pc=%h ins=%h want 1/0/13", INS_VALID, INS_PC, INS); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_rvalid_pop();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
